// File: rtl/encoder_seq_pkg.sv
// rtl/encoder_seq_pkg.sv - shared FSM state encoding and decoder constants
package encoder_seq_pkg;

    // Grant FSM: IDLE waits for a pending bit, GRANT presents an index until ack.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // Reference decoder geometry used for round-trip checks of the encoded index.
    localparam int DEC_N = 4;
    localparam int DEC_W = 2;

    // Behavioural index-to-one-hot decoder, the inverse of the priority encoder.
    function automatic logic [DEC_N-1:0] decoder_behav(input logic [DEC_W-1:0] idx);
        logic [DEC_N-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/encoder_seq_if.sv
// rtl/encoder_seq_if.sv - request/grant bus between producer and encoder_seq
interface encoder_seq_if #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) ();
    logic [N-1:0] req;
    logic         ack;
    logic [W-1:0] out;
    logic         valid;
    logic         more;
    logic [N-1:0] pending;

    // Requester/consumer side: raises requests and acknowledges grants.
    modport master (
        output req,
        output ack,
        input  out,
        input  valid,
        input  more,
        input  pending
    );

    // Encoder side: collects requests and presents granted indices.
    modport slave (
        input  req,
        input  ack,
        output out,
        output valid,
        output more,
        output pending
    );
endinterface

// File: rtl/encoder_seq_prio_enc.sv
// rtl/encoder_seq_prio_enc.sv - combinational highest-set-bit priority encoder
module prio_enc #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);

    // Scan upward so the highest set bit is the last to write idx.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                idx = W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/encoder_seq.sv
// rtl/encoder_seq.sv - sticky request collector granting highest-priority index
module encoder_seq
    import encoder_seq_pkg::*;
#(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    encoder_seq_if.slave      bus
);

    state_e       state_q, state_d;
    logic [N-1:0] pending_q, pending_d;
    logic [W-1:0] out_q, out_d;

    logic [N-1:0] grant_oh;
    logic [N-1:0] clear;
    logic [W-1:0] enc_idx;
    logic         enc_any;
    logic         valid;
    logic         more;

    // Highest pending bit is searched on the registered vector only.
    prio_enc #(
        .N (N),
        .W (W)
    ) u_prio_enc (
        .vec (pending_q),
        .idx (enc_idx),
        .any (enc_any)
    );

    // State, pending and granted-index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            out_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            out_q     <= out_d;
        end
    end

    // Pending update: acknowledged grant clears its bit, new requests win over the clear.
    always_comb begin
        grant_oh  = {{(N-1){1'b0}}, 1'b1} << out_q;
        clear     = (valid && bus.ack) ? grant_oh : '0;
        pending_d = (pending_q & ~clear) | bus.req;
    end

    // Next-state logic; the index is latched only on entry to GRANT so it holds until ack.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        case (state_q)
            ST_IDLE: begin
                if (enc_any) begin
                    state_d = ST_GRANT;
                    out_d   = enc_idx;
                end
            end
            ST_GRANT: begin
                if (bus.ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded purely from registers.
    always_comb begin
        valid = (state_q == ST_GRANT);
        more  = valid && (|(pending_q & ~grant_oh));
    end

    assign bus.valid   = valid;
    assign bus.more    = more;
    assign bus.out     = out_q;
    assign bus.pending = pending_q;

endmodule

// File: doc/encoder_seq.md
ENCODER_SEQ -- requirements
Module: encoder_seq

Interface
REQ-001 Parameter N, default 4, number of request lines (legal: 2..16).
REQ-002 Parameter W, default $clog2(N), width of the encoded index (derived; not overridden).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  N  request lines; a high bit sets the matching pending bit.
REQ-006 ack  input  1  consumer acknowledges the presented index; meaningful only while valid=1.
REQ-007 out  output  W  encoded index of the granted request.
REQ-008 valid  output  1  out holds a granted index awaiting ack.
REQ-009 more  output  1  while valid=1, at least one other pending bit is set.
REQ-010 pending  output  N  sticky pending-request register, for observation.

Function
REQ-011 Each cycle, pending SHALL become (pending & ~clear) | req, where clear is the one-hot of out when valid & ack, else zero.
REQ-012 Simultaneous req bit k and clear of bit k SHALL leave pending[k]=1 (set wins).
REQ-013 FSM states SHALL be IDLE and GRANT; no other reachable states.
REQ-014 IDLE -> GRANT when the registered pending is non-zero; out SHALL load the index of the highest set pending bit (bit N-1 highest priority).
REQ-015 In GRANT, out SHALL stay constant until ack, even if a higher-priority bit is set meanwhile.
REQ-016 GRANT with ack=1 -> IDLE; pending[out] cleared per REQ-011.
REQ-017 GRANT with ack=0 SHALL remain in GRANT; valid held high.
REQ-018 valid SHALL be 1 exactly in GRANT.
REQ-019 ack while valid=0 SHALL be ignored (no state or pending change).
REQ-020 Latency: req asserted in cycle t -> pending set at edge t+1 -> valid=1 after edge t+2.
REQ-021 Back-to-back: ack at edge t, next grant valid after edge t+2 (one IDLE cycle, valid=0).
REQ-022 more SHALL equal valid & |(pending & ~onehot(out)), combinational from registers.
REQ-023 req bits for indices >= N do not exist; out SHALL never exceed N-1.

Reset
REQ-024 rst_n=0 SHALL immediately force: state IDLE, pending all-zero, out=0, valid=0, more=0.
REQ-025 Reset asserted during GRANT SHALL drop the grant with no ack required; requests present during reset are lost.
REQ-026 First rising edge with rst_n=1 SHALL sample req normally.

Structure
REQ-027 FSM state encoding (IDLE, GRANT) SHALL be defined as constants in the shared package alongside the existing decoder constants.
REQ-028 Highest-set-bit search SHALL be a sub-module prio_enc (N-bit in, W-bit index, any flag), purely combinational.
REQ-029 encoder_seq SHALL contain only the pending register, FSM and out register around prio_enc.
REQ-030 Round-trip: decoder_behav(out) SHALL reproduce the one-hot of the granted bit for N=4.

Verification
REQ-031 Reset then req=4'b0100 one cycle -> valid=1 two edges later, out=2'b10, more=0, pending=4'b0100.
REQ-032 req=4'b1011 one cycle -> out=2'b11, more=1; ack -> out=2'b01; ack -> out=2'b00, more=0; ack -> valid=0, pending=0.
REQ-033 Grant on out=2'b01 held with ack=0, then req=4'b1000 -> out stays 2'b01 for 5 cycles; after ack next grant out=2'b11.
REQ-034 In GRANT out=2'b10, ack=1 and req=4'b0100 same cycle -> pending[2] stays 1, re-grant out=2'b10 after IDLE cycle.
REQ-035 rst_n pulled low mid-cycle during GRANT -> valid, out, pending zero before next edge; ack with valid=0 -> no change.
REQ-036 Sweep req over each one-hot 0001..1000 -> out 00..11; feed out to decoder_behav, output equals req.
